// File: rtl/pixel_pkg.sv
// Shared types and palette reset values for the pixel compositor.
// Colour constants are functions of the channel widths, so they work at any R/G/B split.
package pixel_pkg;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        FLASH = 2'd1,
        DARK  = 2'd2
    } state_t;

    function automatic logic [31:0] chanMax(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

    function automatic logic [31:0] packRgb(input logic [31:0] r, input logic [31:0] g,
                                            input logic [31:0] b, input int gW, input int bW);
        return (r << (gW + bW)) | (g << bW) | b;
    endfunction

    // The last entry is always the background and resets to black.
    function automatic logic [31:0] defaultEntry(input int idx, input int rW, input int gW,
                                                 input int bW, input int numEntries);
        if (idx == numEntries - 1) begin
            return 32'd0;
        end
        case (idx)
            0:       return packRgb(32'd0, 32'd0, chanMax(bW), gW, bW);
            1:       return packRgb(chanMax(rW), 32'd0, 32'd0, gW, bW);
            2:       return packRgb(32'd0, chanMax(gW), 32'd0, gW, bW);
            default: return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/palette_regfile.sv
// Writable colour palette: one register per entry, reset to the default colours,
// one write port and one combinational read port (reads see the pre-edge value).
module palette_regfile
    import pixel_pkg::*;
#(
    parameter int R_W         = 3,
    parameter int G_W         = 3,
    parameter int B_W         = 2,
    parameter int NUM_ENTRIES = 5,
    parameter int AW          = 3,
    parameter int PW          = R_W + G_W + B_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [PW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [PW-1:0] rdata
);

    logic [PW-1:0] entryReg [NUM_ENTRIES];

    // Out-of-range write addresses match no entry and are dropped.
    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : gEntry
        localparam logic [PW-1:0] RST_VAL = PW'(defaultEntry(gi, R_W, G_W, B_W, NUM_ENTRIES));

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                entryReg[gi] <= RST_VAL;
            end else if (we && (waddr == AW'(gi))) begin
                entryReg[gi] <= wdata;
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (int'(raddr) < NUM_ENTRIES) begin
            rdata = entryReg[raddr];
        end
    end

endmodule

// File: rtl/pixel_compositor.sv
// Pixel colour compositor: priority-resolves layer hits, maps through the palette,
// applies blanking and the game-over flash/dark sequence, with sync delayed to match.
module pixel_compositor
    import pixel_pkg::*;
#(
    parameter int R_W          = 3,
    parameter int G_W          = 3,
    parameter int B_W          = 2,
    parameter int NUM_LAYERS   = 4,
    parameter int BLINK_FRAMES = 30,
    parameter int GO_FLASHES   = 3,
    localparam int AW          = $clog2(NUM_LAYERS + 1),
    localparam int PW          = R_W + G_W + B_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  video_on,
    input  logic [1:0]            sync_in,
    input  logic [NUM_LAYERS-1:0] layer_hit,
    input  logic                  frame_tick,
    input  logic                  game_over,
    input  logic                  restart,
    input  logic                  pal_we,
    input  logic [AW-1:0]         pal_addr,
    input  logic [PW-1:0]         pal_wdata,
    output logic [R_W-1:0]        vgaRed,
    output logic [G_W-1:0]        vgaGreen,
    output logic [B_W-1:0]        vgaBlue,
    output logic [1:0]            sync_out,
    output logic                  go_active
);

    localparam int FCW = $clog2(BLINK_FRAMES + 1);
    localparam int FLW = (GO_FLASHES > 0) ? $clog2(GO_FLASHES + 1) : 1;

    logic [AW-1:0]  selNext;
    logic [AW-1:0]  selS1Reg;
    logic           videoOnS1Reg;
    logic [1:0]     syncS1Reg;
    logic [PW-1:0]  palColor;
    logic [PW-1:0]  pixNext;
    logic [PW-1:0]  pixReg;
    logic [1:0]     syncOutReg;

    state_t         stateReg, stateNext;
    logic [FCW-1:0] frameCntReg, frameCntNext;
    logic [FLW-1:0] flashCntReg, flashCntNext;
    logic           phaseReg, phaseNext;

    // Scan from the lowest-priority layer down so bit 0 wins.
    always_comb begin
        selNext = AW'(NUM_LAYERS);
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layer_hit[i]) begin
                selNext = AW'(i);
            end
        end
    end

    palette_regfile #(
        .R_W        (R_W),
        .G_W        (G_W),
        .B_W        (B_W),
        .NUM_ENTRIES(NUM_LAYERS + 1),
        .AW         (AW),
        .PW         (PW)
    ) uPalette (
        .clk  (clk),
        .rst  (rst),
        .we   (pal_we),
        .waddr(pal_addr),
        .wdata(pal_wdata),
        .raddr(selS1Reg),
        .rdata(palColor)
    );

    always_comb begin
        stateNext    = stateReg;
        frameCntNext = frameCntReg;
        flashCntNext = flashCntReg;
        phaseNext    = phaseReg;
        case (stateReg)
            PLAY: begin
                if (game_over) begin
                    stateNext    = (GO_FLASHES == 0) ? DARK : FLASH;
                    frameCntNext = '0;
                    flashCntNext = '0;
                    phaseNext    = 1'b0;
                end
            end
            FLASH: begin
                if (restart) begin
                    stateNext    = PLAY;
                    frameCntNext = '0;
                    flashCntNext = '0;
                    phaseNext    = 1'b0;
                end else if (frame_tick) begin
                    if (frameCntReg == FCW'(BLINK_FRAMES - 1)) begin
                        frameCntNext = '0;
                        phaseNext    = ~phaseReg;
                        // A flash completes on the dark-to-bright edge.
                        if (phaseReg) begin
                            flashCntNext = flashCntReg + FLW'(1);
                            if (flashCntReg + FLW'(1) == FLW'(GO_FLASHES)) begin
                                stateNext = DARK;
                            end
                        end
                    end else begin
                        frameCntNext = frameCntReg + FCW'(1);
                    end
                end
            end
            default: begin
                if (restart) begin
                    stateNext    = PLAY;
                    frameCntNext = '0;
                    flashCntNext = '0;
                    phaseNext    = 1'b0;
                end
            end
        endcase
    end

    always_comb begin
        case (stateReg)
            PLAY:    pixNext = palColor;
            FLASH:   pixNext = phaseReg ? '0 : ~palColor;
            default: pixNext = '0;
        endcase
        if (!videoOnS1Reg) begin
            pixNext = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            selS1Reg     <= '0;
            videoOnS1Reg <= 1'b0;
            syncS1Reg    <= '0;
            pixReg       <= '0;
            syncOutReg   <= '0;
            stateReg     <= PLAY;
            frameCntReg  <= '0;
            flashCntReg  <= '0;
            phaseReg     <= 1'b0;
        end else begin
            selS1Reg     <= selNext;
            videoOnS1Reg <= video_on;
            syncS1Reg    <= sync_in;
            pixReg       <= pixNext;
            syncOutReg   <= syncS1Reg;
            stateReg     <= stateNext;
            frameCntReg  <= frameCntNext;
            flashCntReg  <= flashCntNext;
            phaseReg     <= phaseNext;
        end
    end

    assign vgaRed    = pixReg[PW-1 -: R_W];
    assign vgaGreen  = pixReg[B_W +: G_W];
    assign vgaBlue   = pixReg[B_W-1:0];
    assign sync_out  = syncOutReg;
    assign go_active = (stateReg != PLAY);

endmodule

// File: tb/tb_pixel_compositor.sv
// Directed bench for pixel_compositor with BLINK_FRAMES=2, GO_FLASHES=2.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_pixel_compositor;

    logic       clk = 1'b0;
    logic       rst;
    logic       video_on;
    logic [1:0] sync_in;
    logic [3:0] layer_hit;
    logic       frame_tick;
    logic       game_over;
    logic       restart;
    logic       pal_we;
    logic [2:0] pal_addr;
    logic [7:0] pal_wdata;
    logic [2:0] vgaRed;
    logic [2:0] vgaGreen;
    logic [1:0] vgaBlue;
    logic [1:0] sync_out;
    logic       go_active;

    int passCnt  = 0;
    int totalCnt = 0;

    logic [7:0] flashExp [8];
    logic [7:0] rgb;

    assign rgb = {vgaRed, vgaGreen, vgaBlue};

    always #5 clk = ~clk;

    pixel_compositor #(
        .R_W         (3),
        .G_W         (3),
        .B_W         (2),
        .NUM_LAYERS  (4),
        .BLINK_FRAMES(2),
        .GO_FLASHES  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .video_on  (video_on),
        .sync_in   (sync_in),
        .layer_hit (layer_hit),
        .frame_tick(frame_tick),
        .game_over (game_over),
        .restart   (restart),
        .pal_we    (pal_we),
        .pal_addr  (pal_addr),
        .pal_wdata (pal_wdata),
        .vgaRed    (vgaRed),
        .vgaGreen  (vgaGreen),
        .vgaBlue   (vgaBlue),
        .sync_out  (sync_out),
        .go_active (go_active)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        totalCnt++;
        if (got === exp) begin
            passCnt++;
            $display("check %-16s got=%02h exp=%02h ok", tag, got, exp);
        end else begin
            $display("FAIL %-16s got=%02h exp=%02h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
    endtask

    initial begin
        // Inverted {0,7,0} is {7,0,3}; pattern is bright, dark, bright, dark, then DARK.
        flashExp[0] = 8'hE3; flashExp[1] = 8'h00; flashExp[2] = 8'h00; flashExp[3] = 8'hE3;
        flashExp[4] = 8'hE3; flashExp[5] = 8'h00; flashExp[6] = 8'h00; flashExp[7] = 8'h00;

        rst = 1'b0; video_on = 1'b1; sync_in = 2'b11; layer_hit = 4'b0001;
        frame_tick = 1'b0; game_over = 1'b0; restart = 1'b0;
        pal_we = 1'b0; pal_addr = '0; pal_wdata = '0;
        step(); step(); step();
        check("rst_rgb", rgb, 8'h00);
        check("rst_sync", {6'd0, sync_out}, 8'h00);
        check("rst_goactive", {7'd0, go_active}, 8'h00);
        rst = 1'b1;

        layer_hit = 4'b0110; step(); step();
        check("prio_red", rgb, 8'hE0);
        layer_hit = 4'b0001; step(); step();
        check("prio_blue", rgb, 8'h03);
        layer_hit = 4'b0000; step(); step();
        check("bg_default", rgb, 8'h00);

        video_on = 1'b0; layer_hit = 4'b0001; sync_in = 2'b10; step(); step();
        check("blank", rgb, 8'h00);
        check("sync_10", {6'd0, sync_out}, 8'h02);
        sync_in = 2'b01; step();
        check("sync_lat1", {6'd0, sync_out}, 8'h02);
        step();
        check("sync_lat2", {6'd0, sync_out}, 8'h01);

        video_on = 1'b1; layer_hit = 4'b0000;
        pal_we = 1'b1; pal_addr = 3'd4; pal_wdata = 8'hFF; step();
        pal_we = 1'b0; step();
        check("bg_write", rgb, 8'hFF);
        pal_we = 1'b1; pal_addr = 3'd5; pal_wdata = 8'h00; step();
        pal_we = 1'b0; step(); step();
        check("addr5_ignored", rgb, 8'hFF);
        pal_we = 1'b1; pal_addr = 3'd4; pal_wdata = 8'h55; step();
        check("same_cyc_old", rgb, 8'hFF);
        pal_we = 1'b0; step();
        check("same_cyc_new", rgb, 8'h55);

        layer_hit = 4'b0100; step(); step();
        check("play_green", rgb, 8'h1C);
        game_over = 1'b1; step();
        game_over = 1'b0;
        check("go_enter", {7'd0, go_active}, 8'h01);
        step();
        check("flash_first", rgb, 8'hE3);
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("flash_t%0d", i + 1), rgb, flashExp[i]);
            check($sformatf("goact_t%0d", i + 1), {7'd0, go_active}, 8'h01);
        end
        tick();
        check("dark_hold", rgb, 8'h00);

        restart = 1'b1; step();
        restart = 1'b0;
        check("restart_play", {7'd0, go_active}, 8'h00);
        step();
        check("resume_color", rgb, 8'h1C);

        game_over = 1'b1; step();
        game_over = 1'b0;
        tick();
        check("reflash_t1", rgb, 8'hE3);
        restart = 1'b1; game_over = 1'b1; step();
        restart = 1'b0;
        check("both_to_play", {7'd0, go_active}, 8'h00);
        step();
        game_over = 1'b0;
        check("reenter_flash", {7'd0, go_active}, 8'h01);
        check("play_one_cyc", rgb, 8'h1C);
        step();
        tick();
        check("cnt_cleared", rgb, 8'hE3);
        tick();
        check("cnt_toggle", rgb, 8'h00);
        tick(); tick();
        check("pre_rst_flash", rgb, 8'hE3);

        pal_we = 1'b1; pal_addr = 3'd1; pal_wdata = 8'h12; step();
        pal_we = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("async_rgb", rgb, 8'h00);
        check("async_goact", {7'd0, go_active}, 8'h00);
        step();
        rst = 1'b1;
        layer_hit = 4'b0010; step(); step();
        check("dflt_entry1", rgb, 8'hE0);
        check("post_rst_play", {7'd0, go_active}, 8'h00);
        layer_hit = 4'b0000; step(); step();
        check("dflt_bg", rgb, 8'h00);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
